// File: rtl/system_0_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants and FSM state type for the OCI DCT atom packer.
package system_0_nios2_qsys_0_oci_dct_pkg;

  localparam int DCT_WORD_W = 30;
  localparam int DCT_CNT_W  = 4;
  localparam logic [DCT_CNT_W-1:0] DCT_MAX_ATOMS = 4'd15;

  localparam logic [1:0] DCT_ATOM_NONE = 2'b00;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_FLUSHING = 2'd1,
    ST_DONE     = 2'd2
  } dct_state_e;

endpackage

// File: rtl/system_0_nios2_qsys_0_oci_dct_hold.sv
// One-entry valid/ready holding register for completed DCT words (data + atom count).
module system_0_nios2_qsys_0_oci_dct_hold
  import system_0_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DCT_WORD_W-1:0] load_data,
  input  logic [DCT_CNT_W-1:0]  load_count,
  input  logic                  ready,
  output logic                  valid,
  output logic [DCT_WORD_W-1:0] data,
  output logic [DCT_CNT_W-1:0]  count
);

  logic                  valid_q, valid_d;
  logic [DCT_WORD_W-1:0] data_q, data_d;
  logic [DCT_CNT_W-1:0]  count_q, count_d;

  // A load wins over a drain so that move-and-drain in one cycle keeps the entry full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign count = count_q;

endmodule

// File: rtl/system_0_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT atoms into 30-bit words with flush handling and drop tracking.
// Optional macro OCI_DCT_DROP_COUNT_EN enables the saturating dropped-atom counter.
module system_0_nios2_qsys_0_oci_dct_packer
  import system_0_nios2_qsys_0_oci_dct_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            atom,
  input  logic                  flush,
  output logic [DCT_WORD_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  output logic                  word_valid,
  output logic [DCT_WORD_W-1:0] word_data,
  output logic [DCT_CNT_W-1:0]  word_count,
  input  logic                  word_ready,
  output logic                  flush_done,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  dct_state_e            state_q, state_d;
  logic [DCT_WORD_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  flush_done_q, flush_done_d;
  logic                  overflow_q, overflow_d;
  logic                  free, full, take, move, drop;

  always_comb begin
    free = !word_valid || word_ready;
    full = (cnt_q == DCT_MAX_ATOMS);
    take = (atom != DCT_ATOM_NONE) && (state_q != ST_FLUSHING);
    move = free && (full || ((state_q == ST_FLUSHING) && (cnt_q != '0)));
    drop = take && full && !move;

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (move) begin
      buf_d = '0;
      cnt_d = '0;
      // The cleared buffer can absorb an atom arriving in the move cycle.
      if (take) begin
        buf_d = {{(DCT_WORD_W-2){1'b0}}, atom};
        cnt_d = 4'd1;
      end
    end else if (take && !full) begin
      buf_d = {buf_q[DCT_WORD_W-3:0], atom};
      cnt_d = cnt_q + 4'd1;
    end
    overflow_d = overflow_q | drop;
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      ST_ACTIVE:   if (flush) state_d = ST_FLUSHING;
      ST_FLUSHING: if ((cnt_q == '0) && !word_valid) begin
        state_d      = ST_DONE;
        flush_done_d = 1'b1;
      end
      ST_DONE:     state_d = ST_ACTIVE;
      default:     state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ACTIVE;
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
    end
  end

  system_0_nios2_qsys_0_oci_dct_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (move),
    .load_data  (buf_q),
    .load_count (cnt_q),
    .ready      (word_ready),
    .valid      (word_valid),
    .data       (word_data),
    .count      (word_count)
  );

`ifdef OCI_DCT_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign flush_done = flush_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_system_0_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_system_0_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  atom;
  logic        flush;
  logic        word_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic        flush_done;
  logic        overflow;
  logic [7:0]  drop_count;

  system_0_nios2_qsys_0_oci_dct_packer #(.DROP_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .atom(atom), .flush(flush),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .word_valid(word_valid), .word_data(word_data), .word_count(word_count),
    .word_ready(word_ready), .flush_done(flush_done),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: buffer and held word as queues of atoms, oldest first.
  bit [1:0] m_buf[$];
  bit [1:0] m_hold[$];
  bit       m_hv, m_done, m_ovf;
  int       m_drops;
  int       m_st;  // 0 active, 1 flushing, 2 done

  function automatic logic [29:0] pack(input bit [1:0] q[$]);
    logic [29:0] v = '0;
    foreach (q[i]) v = (v << 2) | 30'(q[i]);
    return v;
  endfunction

  function automatic logic [31:0] exp_drops();
`ifdef OCI_DCT_DROP_COUNT_EN
    return (m_drops > 255) ? 32'd255 : 32'(m_drops);
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_buf.delete(); m_hold.delete();
    m_hv = 0; m_done = 0; m_ovf = 0; m_drops = 0; m_st = 0;
  endtask

  task automatic model_step(input bit [1:0] a, input bit f, input bit r);
    int  cnt = m_buf.size();
    bit  fr  = !m_hv || r;
    bit  mv  = fr && (cnt == 15 || (m_st == 1 && cnt != 0));
    int  nst = m_st;
    m_done = 0;
    if (m_st == 0 && f) nst = 1;
    else if (m_st == 1 && cnt == 0 && !m_hv) begin nst = 2; m_done = 1; end
    else if (m_st == 2) nst = 0;
    if (mv) begin m_hold = m_buf; m_hv = 1; m_buf.delete(); end
    else if (r) m_hv = 0;
    if (a != 0 && m_st != 1) begin
      if (m_buf.size() < 15) m_buf.push_back(a);
      else begin m_ovf = 1; m_drops++; end
    end
    m_st = nst;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dct_buffer", 32'(dct_buffer), 32'(pack(m_buf)));
    chk("dct_count",  32'(dct_count),  32'(m_buf.size()));
    chk("word_valid", 32'(word_valid), 32'(m_hv));
    chk("word_data",  32'(word_data),  32'(pack(m_hold)));
    chk("word_count", 32'(word_count), 32'(m_hold.size()));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("drop_count", 32'(drop_count), exp_drops());
  endtask

  task automatic cycle(input bit [1:0] a, input bit f, input bit r);
    atom = a; flush = f; word_ready = r;
    @(posedge clk);
    model_step(a, f, r);
    #1;
    check_all();
  endtask

  initial begin
    logic [29:0] saved_drops;
    reset = 1'b1; atom = 2'b00; flush = 1'b0; word_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // 15 atoms of 01 with ready high, then the move
    for (int i = 1; i <= 15; i++) begin
      cycle(2'b01, 0, 1);
      chk("ramp_count", 32'(dct_count), 32'(i));
    end
    cycle(2'b00, 0, 1);
    chk("full_word_data", 32'(word_data), 32'h15555555);
    chk("full_word_count", 32'(word_count), 32'd15);
    chk("full_word_valid", 32'(word_valid), 32'd1);
    chk("full_cnt_zero", 32'(dct_count), 32'd0);
    cycle(2'b00, 0, 1);

    // partial word 01,10,11 then flush
    cycle(2'b01, 0, 1); cycle(2'b10, 0, 1); cycle(2'b11, 0, 1);
    cycle(2'b00, 1, 1);
    cycle(2'b00, 0, 0);
    chk("partial_data", 32'(word_data), 32'h1B);
    chk("partial_count", 32'(word_count), 32'd3);
    cycle(2'b00, 0, 1);
    chk("partial_done_early", 32'(flush_done), 32'd0);
    cycle(2'b00, 0, 1);
    chk("partial_done", 32'(flush_done), 32'd1);
    cycle(2'b00, 0, 1);
    chk("partial_done_once", 32'(flush_done), 32'd0);

    // 31 atoms against a stalled consumer
    for (int i = 0; i < 31; i++) cycle(2'($urandom_range(3, 1)), 0, 0);
    chk("stall_overflow", 32'(overflow), 32'd1);
    chk("stall_cnt_full", 32'(dct_count), 32'd15);
`ifdef OCI_DCT_DROP_COUNT_EN
    chk("stall_drop_one", 32'(drop_count), 32'd1);
`endif
    cycle(2'b00, 0, 1);
    chk("move_drain_valid", 32'(word_valid), 32'd1);
    chk("move_drain_cnt", 32'(dct_count), 32'd0);
    cycle(2'b00, 0, 1);

    // 16th atom in the move cycle is kept
    saved_drops = 30'(drop_count);
    for (int i = 0; i < 15; i++) cycle(2'($urandom_range(3, 1)), 0, 1);
    cycle(2'b10, 0, 1);
    chk("sixteenth_cnt", 32'(dct_count), 32'd1);
    chk("sixteenth_buf", 32'(dct_buffer), 32'd2);
    chk("sixteenth_nodrop", 32'(drop_count), 32'(saved_drops));
    cycle(2'b00, 1, 1);
    for (int i = 0; i < 6; i++) cycle(2'b00, 0, 1);

    // empty flush with atoms during FLUSHING
    saved_drops = 30'(drop_count);
    cycle(2'b00, 1, 1);
    chk("empty_flush_t1", 32'(flush_done), 32'd0);
    cycle(2'b11, 0, 1);
    chk("empty_flush_t2", 32'(flush_done), 32'd1);
    chk("flushing_ignore", 32'(dct_count), 32'd0);
    chk("flushing_nodrop", 32'(drop_count), 32'(saved_drops));
    cycle(2'b00, 0, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle(2'($urandom_range(3, 0)), ($urandom_range(19, 0) == 0), 1'($urandom_range(1, 0)));

    // reset mid-word while a flush is pending
    for (int i = 0; i < 16; i++) cycle(2'b01, 0, 0);
    cycle(2'b01, 1, 0);
    chk("pre_reset_valid", 32'(word_valid), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("reset_word_valid", 32'(word_valid), 32'd0);
    chk("reset_cnt", 32'(dct_count), 32'd0);
    @(posedge clk); #1;
    chk("reset_no_done", 32'(flush_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(2'b00, 0, 1);
      chk("post_reset_no_done", 32'(flush_done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/system_0_nios2_qsys_0_oci_dct_packer.md
# system_0_nios2_qsys_0_oci_dct_packer

Packs the 2-bit data-compression-trace (DCT) atoms produced by the Nios II OCI into 30-bit words of up to 15 atoms. It sits directly upstream of the OCI trace consumer and test bench: it drives the live `dct_buffer`/`dct_count` pair and hands completed words downstream through a valid/ready holding register. A flush request drains any partial word and signals completion.

## Interface
Parameters:
- `DROP_CNT_W`, 8: width of the dropped-atom counter; only used with `OCI_DCT_DROP_COUNT_EN`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `atom`  in  2  trace atom; `00` = no atom this cycle; `01`, `10`, `11` = valid atoms.
- `flush`  in  1  single-cycle request to emit the partial word.
- `dct_buffer`  out  30  live packing buffer.
- `dct_count`  out  4  atoms held in `dct_buffer` (0..15).
- `word_valid`  out  1  holding register full.
- `word_data`  out  30  held word.
- `word_count`  out  4  atoms in held word (1..15).
- `word_ready`  in  1  downstream accepts the held word.
- `flush_done`  out  1  one-cycle pulse when a flush has fully drained.
- `overflow`  out  1  sticky: at least one atom dropped since reset.
- `drop_count`  out  `DROP_CNT_W`  saturating dropped-atom count.

## Operation
- Packing: accepted atom shifts into the LSBs: `dct_buffer <= {dct_buffer[27:0], atom}`, `dct_count += 1`. Oldest atom ends up in the MSBs.
- `free = !word_valid || word_ready`.
- Move: when (`dct_count == 15`, or state FLUSHING and `dct_count != 0`) and `free`, the holding register loads `dct_buffer`/`dct_count`, the buffer clears. A valid atom in the same cycle is accepted into the cleared buffer (count = 1), except in FLUSHING.
- Holding: `word_valid` set on move; cleared on `word_ready` when no move occurs that cycle. Move and drain in the same cycle keep `word_valid` high with new data.
- Drop: valid atom while `dct_count == 15` and no move this cycle is discarded; `overflow` sets; `drop_count` increments, saturating at all-ones.
- FSM states:
  - ACTIVE: normal packing. `flush` -> FLUSHING.
  - FLUSHING: valid atoms are ignored (not counted as drops). Partial word moves when `free`. When `dct_count == 0` and `word_valid == 0` -> DONE.
  - DONE: `flush_done = 1` for exactly this cycle; -> ACTIVE.
- `flush` while FLUSHING or DONE is ignored.
- `flush` with an empty buffer and empty holding register: ACTIVE -> FLUSHING -> DONE; `flush_done` occurs 2 cycles after `flush`.

## Timing
- Reset (asynchronous): state ACTIVE; `dct_buffer`, `dct_count`, `word_valid`, `word_data`, `word_count`, `flush_done`, `overflow`, `drop_count` all 0.
- Reset asserted mid-operation discards all buffered and held atoms immediately. No `flush_done` is generated.
- An atom presented at edge N is visible in `dct_buffer`/`dct_count` after edge N.
- The 15th atom at edge N gives count 15 after N. The move occurs at edge N+1 if `free`. `word_valid` is high after N+1.
- `word_data`/`word_count` stay stable while `word_valid && !word_ready`.
- All outputs are registered. No combinational path from `word_ready` to any output.

## Configuration
- `OCI_DCT_DROP_COUNT_EN` defined: `drop_count` is the saturating counter described above.
- `OCI_DCT_DROP_COUNT_EN` undefined: no counter logic; `drop_count` is tied to 0. `overflow` still functions.

## Structure
- Package `system_0_nios2_qsys_0_oci_dct_pkg` holds:
  - constants `DCT_WORD_W = 30`, `DCT_CNT_W = 4`, `DCT_MAX_ATOMS = 15`;
  - atom codes `DCT_ATOM_NONE = 2'b00`;
  - the FSM state enum (ACTIVE, FLUSHING, DONE).
- Sub-module `system_0_nios2_qsys_0_oci_dct_hold` implements the one-entry valid/ready holding register (data + count). The top level contains the packer, FSM and drop logic.

## Test plan
- Feed 15 atoms `01` back-to-back with `word_ready = 1`:
  - `dct_count` counts 1..15;
  - one cycle later `word_valid = 1`, `word_data = 30'h15555555`, `word_count = 15`;
  - `dct_count` returns to 0.
- Feed atoms `01,10,11`, then `flush`:
  - `word_data = 30'h1B`, `word_count = 3`;
  - `flush_done` pulses once after the word is accepted.
- Hold `word_ready = 0` and feed 31 atoms:
  - the first 15 are held and the next 15 fill the buffer;
  - the 31st sets `overflow = 1` and `drop_count = 1`.
  - Then raise `word_ready`: the second word moves in the same cycle the first drains.
- Feed a 16th atom in the move cycle with `word_ready = 1`:
  - the atom is not dropped; `dct_count = 1` after the move.
- `flush` with nothing buffered:
  - `flush_done` exactly 2 cycles later;
  - atoms presented during FLUSHING are ignored and `drop_count` is unchanged.
- Assert `reset` mid-word with `word_valid = 1`:
  - all outputs read 0 immediately;
  - no `flush_done` pulse.
